// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - word-addressed data memory with valid/ready request port and registered responses
//
// Purpose: MEM-stage load/store unit. Holds DEPTH 32-bit words, performs
// byte/half/word stores and signed/unsigned sub-word loads, flags misaligned
// or out-of-range accesses, clears the array after reset, and emits a
// merged-word store log.
//
// Ports:
//   i_clk, i_reset (async active-low)
//   i_req_valid / o_req_ready        request handshake
//   i_req_op, i_req_addr, i_req_wdata, i_req_pc   request payload
//   o_rsp_valid, o_rsp_rdata, o_rsp_err           response, one cycle after accept
//   o_m_data_byteen                  lanes written by the last accepted store
//   o_wr_log_valid/addr/data/pc      store trace

module dm_lsu #(
   parameter int          DEPTH      = 3072,
   parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
   parameter bit          INIT_CLEAR = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [2:0]  i_req_op,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [31:0] i_req_pc,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic [3:0]  o_m_data_byteen,
   output logic        o_wr_log_valid,
   output logic [31:0] o_wr_log_addr,
   output logic [31:0] o_wr_log_data,
   output logic [31:0] o_wr_log_pc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {S_INIT, S_IDLE} state_t;

   state_t         r_state;
   logic [AW-1:0]  r_cnt;
   logic [31:0]    r_mem [DEPTH];

   logic           w_accept;
   logic           w_is_store;
   logic           w_is_word;
   logic           w_is_half;
   logic [31:0]    w_off;
   logic           w_oor;
   logic           w_mis;
   logic           w_err;
   logic [AW-1:0]  w_idx;
   logic [31:0]    w_old;
   logic [3:0]     w_be;
   logic [31:0]    w_sdata;
   logic [31:0]    w_merged;
   logic [7:0]     w_byte;
   logic [15:0]    w_half;
   logic [31:0]    w_load;
   logic           w_mem_we;
   logic [AW-1:0]  w_mem_idx;
   logic [31:0]    w_mem_wdata;

   assign w_accept   = i_req_valid && o_req_ready;
   assign w_is_store = i_req_op[2] && (i_req_op[1] || i_req_op[0]);
   assign w_is_word  = (i_req_op == 3'b000) || (i_req_op == 3'b101);
   assign w_is_half  = (i_req_op == 3'b001) || (i_req_op == 3'b010) || (i_req_op == 3'b110);

   // ADDR_BASE is word-aligned, so alignment can be judged on the raw address.
   assign w_off = i_req_addr - ADDR_BASE;
   assign w_oor = (i_req_addr < ADDR_BASE) || (w_off[31:2] >= 30'(DEPTH));
   assign w_mis = (w_is_word && (i_req_addr[1:0] != 2'b00)) || (w_is_half && i_req_addr[0]);
   assign w_err = w_oor || w_mis;
   assign w_idx = w_off[AW+1:2];
   assign w_old = r_mem[w_idx];

   always_comb begin
      w_be    = 4'b0000;
      w_sdata = i_req_wdata;
      case (i_req_op)
         3'b101: w_be = 4'b1111;
         3'b110: begin
            w_be    = i_req_addr[1] ? 4'b1100 : 4'b0011;
            w_sdata = {2{i_req_wdata[15:0]}};
         end
         3'b111: begin
            w_be    = 4'b0001 << i_req_addr[1:0];
            w_sdata = {4{i_req_wdata[7:0]}};
         end
         default: w_be = 4'b0000;
      endcase
   end

   // Stores write the whole word: untouched lanes carry the old bytes back.
   always_comb begin
      w_merged = w_old;
      for (int i = 0; i < 4; i++) begin
         if (w_be[i]) w_merged[8*i +: 8] = w_sdata[8*i +: 8];
      end
   end

   assign w_byte = w_old[{i_req_addr[1:0], 3'b000} +: 8];
   assign w_half = i_req_addr[1] ? w_old[31:16] : w_old[15:0];

   always_comb begin
      w_load = 32'h0;
      case (i_req_op)
         3'b000:  w_load = w_old;
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b010:  w_load = {16'h0, w_half};
         3'b011:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {24'h0, w_byte};
         default: w_load = 32'h0;
      endcase
   end

   // The clearing sweep and accepted stores share the single write port;
   // they never overlap because ready is low throughout the sweep.
   assign w_mem_we    = i_reset && ((r_state == S_INIT) || (w_accept && w_is_store && !w_err));
   assign w_mem_idx   = (r_state == S_INIT) ? r_cnt : w_idx;
   assign w_mem_wdata = (r_state == S_INIT) ? 32'h0 : w_merged;

   always_ff @(posedge i_clk) begin
      if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state         <= INIT_CLEAR ? S_INIT : S_IDLE;
         r_cnt           <= '0;
         o_req_ready     <= 1'b0;
         o_rsp_valid     <= 1'b0;
         o_rsp_rdata     <= 32'h0;
         o_rsp_err       <= 1'b0;
         o_m_data_byteen <= 4'b0000;
         o_wr_log_valid  <= 1'b0;
         o_wr_log_addr   <= 32'h0;
         o_wr_log_data   <= 32'h0;
         o_wr_log_pc     <= 32'h0;
      end else begin
         o_rsp_valid     <= 1'b0;
         o_rsp_err       <= 1'b0;
         o_m_data_byteen <= 4'b0000;
         o_wr_log_valid  <= 1'b0;
         case (r_state)
            S_INIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == AW'(DEPTH - 1)) begin
                  r_state     <= S_IDLE;
                  r_cnt       <= '0;
                  o_req_ready <= 1'b1;
               end
            end
            default: begin
               o_req_ready <= 1'b1;
               if (w_accept) begin
                  o_rsp_valid <= 1'b1;
                  o_rsp_err   <= w_err;
                  if (w_err || w_is_store) begin
                     o_rsp_rdata <= 32'h0;
                  end else begin
                     o_rsp_rdata <= w_load;
                  end
                  if (w_is_store && !w_err) begin
                     o_m_data_byteen <= w_be;
                     o_wr_log_valid  <= 1'b1;
                     o_wr_log_addr   <= {i_req_addr[31:2], 2'b00};
                     o_wr_log_data   <= w_merged;
                     o_wr_log_pc     <= i_req_pc;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_lsu.sv
// tb/tb_dm_lsu.sv - directed self-checking bench for dm_lsu (DEPTH=16)

module tb_dm_lsu;

   localparam int DEPTH = 16;

   localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                          LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [31:0] req_pc = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [3:0]  byteen;
   logic        log_valid;
   logic [31:0] log_addr;
   logic [31:0] log_data;
   logic [31:0] log_pc;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dm_lsu #(.DEPTH(DEPTH), .ADDR_BASE(32'h0), .INIT_CLEAR(1'b1)) dut (
      .i_clk(clk), .i_reset(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_op(req_op), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_pc(req_pc),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
      .o_m_data_byteen(byteen),
      .o_wr_log_valid(log_valid), .o_wr_log_addr(log_addr),
      .o_wr_log_data(log_data), .o_wr_log_pc(log_pc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " ready"}, 32'(req_ready), 32'h0);
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
      chk({tag, " rsp_err"}, 32'(rsp_err), 32'h0);
      chk({tag, " rdata"}, rsp_rdata, 32'h0);
      chk({tag, " byteen"}, 32'(byteen), 32'h0);
      chk({tag, " log_valid"}, 32'(log_valid), 32'h0);
      chk({tag, " log_addr"}, log_addr, 32'h0);
      chk({tag, " log_data"}, log_data, 32'h0);
      chk({tag, " log_pc"}, log_pc, 32'h0);
   endtask

   // Called #1 after reset release; counts edges until ready rises.
   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      chk({tag, " ready low at release"}, 32'(req_ready), 32'h0);
      while (!req_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, " sweep cycles"}, 32'(n), 32'(DEPTH));
   endtask

   // Drives one request and samples its response #1 after the accepting edge.
   task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      req_pc    = pc;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic load_chk(input string tag, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] exp);
      do_req(op, addr, 32'h0, 32'h0);
      chk({tag, " valid"}, 32'(rsp_valid), 32'h1);
      chk({tag, " err"}, 32'(rsp_err), 32'h0);
      chk({tag, " rdata"}, rsp_rdata, exp);
      chk({tag, " byteen"}, 32'(byteen), 32'h0);
   endtask

   task automatic store_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] pc,
                            input logic [3:0] exp_be, input logic [31:0] exp_word);
      do_req(op, addr, wdata, pc);
      chk({tag, " valid"}, 32'(rsp_valid), 32'h1);
      chk({tag, " err"}, 32'(rsp_err), 32'h0);
      chk({tag, " rdata"}, rsp_rdata, 32'h0);
      chk({tag, " byteen"}, 32'(byteen), 32'(exp_be));
      chk({tag, " log_valid"}, 32'(log_valid), 32'h1);
      chk({tag, " log_addr"}, log_addr, {addr[31:2], 2'b00});
      chk({tag, " log_data"}, log_data, exp_word);
      chk({tag, " log_pc"}, log_pc, pc);
   endtask

   task automatic err_chk(input string tag, input logic [2:0] op, input logic [31:0] addr);
      do_req(op, addr, 32'hFFFF_FFFF, 32'h0);
      chk({tag, " valid"}, 32'(rsp_valid), 32'h1);
      chk({tag, " err"}, 32'(rsp_err), 32'h1);
      chk({tag, " rdata"}, rsp_rdata, 32'h0);
      chk({tag, " byteen"}, 32'(byteen), 32'h0);
      chk({tag, " log_valid"}, 32'(log_valid), 32'h0);
   endtask

   initial begin
      #3;
      chk_all_zero("in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      wait_ready("sweep1");

      load_chk("lw_3c", LW, 32'h3C, 32'h0);

      store_chk("sw_08", SW, 32'h08, 32'h8899AABB, 32'h100, 4'b1111, 32'h8899AABB);
      load_chk("lb_09", LB, 32'h09, 32'hFFFFFFAA);
      load_chk("lbu_09", LBU, 32'h09, 32'h000000AA);
      load_chk("lh_0a", LH, 32'h0A, 32'hFFFF8899);
      load_chk("lhu_08", LHU, 32'h08, 32'h0000AABB);

      @(posedge clk);
      #1;
      chk("idle valid", 32'(rsp_valid), 32'h0);
      chk("idle rdata hold", rsp_rdata, 32'h0000AABB);
      chk("idle log_valid", 32'(log_valid), 32'h0);

      store_chk("sb_0b", SB, 32'h0B, 32'h00000012, 32'h104, 4'b1000, 32'h1299AABB);
      store_chk("sh_08", SH, 32'h08, 32'h00003456, 32'h108, 4'b0011, 32'h12993456);
      load_chk("lw_08", LW, 32'h08, 32'h12993456);

      err_chk("sw_06 mis", SW, 32'h06);
      err_chk("lh_01 mis", LH, 32'h01);
      err_chk("sw_40 oor", SW, 32'h40);
      load_chk("lw_04 after err", LW, 32'h04, 32'h0);

      store_chk("b2b sw_10", SW, 32'h10, 32'hDEADBEEF, 32'h10C, 4'b1111, 32'hDEADBEEF);
      load_chk("b2b lw_10", LW, 32'h10, 32'hDEADBEEF);

      // Reset in the middle of traffic: outputs clear without a clock edge.
      store_chk("sw_14", SW, 32'h14, 32'h11223344, 32'h200, 4'b1111, 32'h11223344);
      req_valid = 1'b1;
      req_op    = LW;
      req_addr  = 32'h14;
      @(posedge clk);
      #1;
      chk("lw_14 rdata", rsp_rdata, 32'h11223344);
      #2;
      rst_n = 1'b0;
      #1;
      req_valid = 1'b0;
      chk_all_zero("rst_traffic");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      wait_ready("sweep2");

      store_chk("sw_10 pre", SW, 32'h10, 32'hCAFEF00D, 32'h300, 4'b1111, 32'hCAFEF00D);

      // Reset at sweep count 7: the sweep must restart and clear word 4 again.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (7) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_sweep");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      wait_ready("sweep3");
      load_chk("lw_10 cleared", LW, 32'h10, 32'h0);
      load_chk("lw_14 cleared", LW, 32'h14, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
